// File: rtl/axis_byte_packer_pkg.sv
// Shared constants and helpers for the AXI-Stream byte packer.
package axis_byte_packer_pkg;

   localparam int DEF_S_WIDTH   = 8;
   localparam int DEF_RATIO     = 4;
   localparam int DEF_CNT_WIDTH = 16;
   localparam int MASK_WIDTH    = 32;

   typedef logic [MASK_WIDTH-1:0] lane_mask_t;

   // Keep mask covering lanes 0..lane inclusive: (1 << (lane+1)) - 1.
   function automatic lane_mask_t lane_mask(input int unsigned lane);
      lane_mask_t one_v;
      one_v = lane_mask_t'(1);
      return (one_v << (lane + 32'd1)) - one_v;
   endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// AXI-Stream bundle used on both sides of the packer (tkeep unused on the byte side).
interface axis_byte_packer_if #(
   parameter int DW = 8,
   parameter int KW = 1
);

   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (
      output tdata,
      output tkeep,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_byte_packer_out_reg.sv
// Single-entry registered output stage: holds one packed word until the sink accepts it.
module axis_byte_packer_out_reg
   import axis_byte_packer_pkg::*;
#(
   parameter  int S_WIDTH = DEF_S_WIDTH,
   parameter  int RATIO   = DEF_RATIO,
   localparam int M_WIDTH = S_WIDTH * RATIO
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [M_WIDTH-1:0] load_data_i,
   input  logic [RATIO-1:0]   load_keep_i,
   input  logic               load_last_i,
   axis_byte_packer_if.master m_axis,
   output logic               accept_o
);

   logic [M_WIDTH-1:0] data_q, data_d;
   logic [RATIO-1:0]   keep_q, keep_d;
   logic               last_q, last_d;
   logic               valid_q, valid_d;
   logic               accept_s;

   // A load on the same edge as an accept replaces the old word and keeps valid high.
   always_comb begin
      accept_s = valid_q && m_axis.tready;
      data_d   = data_q;
      keep_d   = keep_q;
      last_d   = last_q;
      valid_d  = valid_q;
      if (load_i) begin
         data_d  = load_data_i;
         keep_d  = load_keep_i;
         last_d  = load_last_i;
         valid_d = 1'b1;
      end else if (accept_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign m_axis.tdata  = data_q;
   assign m_axis.tkeep  = keep_q;
   assign m_axis.tlast  = last_q;
   assign m_axis.tvalid = valid_q;
   assign accept_o      = accept_s;

endmodule

// File: rtl/axis_byte_packer.sv
// Packs RATIO consecutive stream bytes into one little-endian word; tlast flushes a partial word.
module axis_byte_packer
   import axis_byte_packer_pkg::*;
#(
   parameter  int S_WIDTH   = DEF_S_WIDTH,
   parameter  int RATIO     = DEF_RATIO,
   parameter  int CNT_WIDTH = DEF_CNT_WIDTH,
   localparam int M_WIDTH   = S_WIDTH * RATIO
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axis_byte_packer_if.slave    s_axis,
   axis_byte_packer_if.master   m_axis,
   output logic [CNT_WIDTH-1:0] frame_count
);

   localparam int LANE_W = $clog2(RATIO);

   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [M_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;

   logic                 s_ready_s;
   logic                 in_xfer_s;
   logic                 complete_s;
   logic                 out_accept_s;
   logic [M_WIDTH-1:0]   merged_s;
   lane_mask_t           mask_s;
   logic [RATIO-1:0]     keep_load_s;

   // Ready depends only on the output stage, never on the input valid.
   assign s_ready_s     = rst_n && (!m_axis.tvalid || m_axis.tready);
   assign s_axis.tready = s_ready_s;

   always_comb begin
      in_xfer_s   = s_axis.tvalid && s_ready_s;
      complete_s  = in_xfer_s && ((lane_q == LANE_W'(RATIO - 1)) || s_axis.tlast);
      mask_s      = lane_mask(32'(lane_q));
      keep_load_s = mask_s[RATIO-1:0];
      merged_s    = acc_q;
      for (int i = 0; i < RATIO; i++) begin
         if (lane_q == LANE_W'(i)) begin
            merged_s[i*S_WIDTH +: S_WIDTH] = s_axis.tdata;
         end else begin
            merged_s[i*S_WIDTH +: S_WIDTH] = acc_q[i*S_WIDTH +: S_WIDTH];
         end
      end
   end

   // Lanes above the current index stay zero, so a flushed partial word has zeroed upper lanes.
   always_comb begin
      lane_d = lane_q;
      acc_d  = acc_q;
      if (complete_s) begin
         lane_d = '0;
         acc_d  = '0;
      end else if (in_xfer_s) begin
         lane_d = lane_q + LANE_W'(1);
         acc_d  = merged_s;
      end else begin
         lane_d = lane_q;
         acc_d  = acc_q;
      end
   end

   always_comb begin
      fcnt_d = fcnt_q;
      if (out_accept_s && m_axis.tlast) begin
         fcnt_d = fcnt_q + CNT_WIDTH'(1);
      end else begin
         fcnt_d = fcnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q <= '0;
         acc_q  <= '0;
         fcnt_q <= '0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign frame_count = fcnt_q;

   axis_byte_packer_out_reg #(
      .S_WIDTH (S_WIDTH),
      .RATIO   (RATIO)
   ) u_out_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (complete_s),
      .load_data_i (merged_s),
      .load_keep_i (keep_load_s),
      .load_last_i (s_axis.tlast),
      .m_axis      (m_axis),
      .accept_o    (out_accept_s)
   );

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer (RATIO=4, CNT_WIDTH=4 to reach the counter wrap).
module tb_axis_byte_packer;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] frame_count;
   int         checks;
   int         failures;
   exp_t       exp_q[$];

   axis_byte_packer_if #(.DW(8),  .KW(1)) s_if ();
   axis_byte_packer_if #(.DW(32), .KW(4)) m_if ();

   axis_byte_packer #(
      .S_WIDTH   (8),
      .RATIO     (4),
      .CNT_WIDTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_axis      (s_if.slave),
      .m_axis      (m_if.master),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endfunction

   // Monitor: every accepted output beat is compared against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && m_if.tvalid && m_if.tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(m_if.tdata), 64'hDEAD_BEEF_DEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            check("tdata", 64'(m_if.tdata), 64'(e.d));
            check("tkeep", 64'(m_if.tkeep), 64'(e.k));
            check("tlast", 64'(m_if.tlast), 64'(e.l));
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_t e;
      e.d = d;
      e.k = k;
      e.l = l;
      exp_q.push_back(e);
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      while (!s_if.tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("send_timeout", 64'(n), 64'd0);
      end else begin
         @(posedge clk);
      end
      @(negedge clk);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
      check("rst_tdata", 64'(m_if.tdata), 64'd0);
      check("rst_tkeep", 64'(m_if.tkeep), 64'd0);
      check("rst_tlast", 64'(m_if.tlast), 64'd0);
      check("rst_s_tready", 64'(s_if.tready), 64'd0);
      check("rst_frame_count", 64'(frame_count), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic stall_proc();
      int n;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         if (m_if.tvalid) break;
         n++;
      end
      check("stall_word_seen", 64'(m_if.tvalid), 64'd1);
      m_if.tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_s_tready", 64'(s_if.tready), 64'd0);
         check("stall_hold_data", 64'(m_if.tdata), 64'h0302_0100);
         check("stall_hold_valid", 64'(m_if.tvalid), 64'd1);
         @(posedge clk);
         #1;
      end
      m_if.tready = 1'b1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      s_if.tdata  = 8'h00;
      s_if.tkeep  = 1'b1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(negedge clk);
      pulse_reset();

      // Full word with tlast on the fourth byte, checking single-cycle latency.
      push(32'h4433_2211, 4'b1111, 1'b1);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      check("latency_tvalid", 64'(m_if.tvalid), 64'd1);
      drain();
      check("fc_full", 64'(frame_count), 64'd1);

      // Partial flush.
      push(32'h00C3_B2A1, 4'b0111, 1'b1);
      send(8'hA1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hC3, 1'b1);
      drain();
      check("fc_partial", 64'(frame_count), 64'd2);

      // tlast on lane 0.
      push(32'h0000_005A, 4'b0001, 1'b1);
      send(8'h5A, 1'b1);
      drain();
      check("fc_lane0", 64'(frame_count), 64'd3);

      // Backpressure across a 12-byte frame.
      push(32'h0302_0100, 4'b1111, 1'b0);
      push(32'h0706_0504, 4'b1111, 1'b0);
      push(32'h0B0A_0908, 4'b1111, 1'b1);
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               send(8'(i), (i == 11) ? 1'b1 : 1'b0);
            end
         end
         stall_proc();
      join
      drain();
      check("fc_backpressure", 64'(frame_count), 64'd4);

      // Reset mid-frame discards the partial word.
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      pulse_reset();
      push(32'h0605_0403, 4'b1111, 1'b1);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      send(8'h05, 1'b0);
      send(8'h06, 1'b1);
      drain();
      check("fc_after_reset", 64'(frame_count), 64'd1);

      // Frame counter wrap at 4 bits.
      pulse_reset();
      for (int i = 1; i <= 16; i++) begin
         push(32'(i), 4'b0001, 1'b1);
         send(8'(i), 1'b1);
      end
      drain();
      check("fc_wrap16", 64'(frame_count), 64'd0);
      push(32'h0000_0011, 4'b0001, 1'b1);
      send(8'h11, 1'b1);
      drain();
      check("fc_wrap17", 64'(frame_count), 64'd1);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
